// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int         BYTE_W     = 8;
    localparam int         ID_W       = 4;
    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEND,
        WAIT,
        NEXT
    } arb_state_t;

    function automatic logic [BYTE_W-1:0] hdr_byte(input logic [ID_W-1:0] id);
        return {HDR_NIBBLE, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first valid requester at or above ptr_i, wrapping modulo N_REQ.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  grant_o,
    output logic             any_o
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] oh;

    always_comb begin
        // Rotate so ptr_i lands at bit 0, then isolate the lowest set bit.
        rot     = N_REQ'({valid_i, valid_i} >> ptr_i);
        oh      = rot & (~rot + 1'b1);
        grant_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                grant_o = ID_W'((i + int'(ptr_i)) % N_REQ);
            end
        end
        any_o = |valid_i;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among N_REQ byte streams,
// with optional requester-ID header byte and a done-watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter bit ID_PREFIX = 1'b0,
    parameter int TIMEOUT   = 65535,
    localparam int CNT_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]       tx_din,
    output logic                    tx_enable,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    err_timeout
);

    arb_state_t        state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   grant_q;
    logic              last_q;
    logic              hdr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BYTE_W-1:0] tx_din_q;
    logic              tx_en_q;
    logic [N_REQ-1:0]  ready_q;
    logic              busy_q;
    logic              err_q;

    logic [ID_W-1:0]   arb_grant;
    logic              arb_any;
    logic [BYTE_W-1:0] sel_byte_d;
    logic              sel_last_d;
    logic              sel_valid_d;
    logic [N_REQ-1:0]  grant_oh_d;
    logic [ID_W-1:0]   ptr_adv_d;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    always_comb begin
        sel_byte_d  = '0;
        sel_last_d  = 1'b0;
        sel_valid_d = 1'b0;
        grant_oh_d  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_byte_d    = req_data[i*BYTE_W +: BYTE_W];
                sel_last_d    = req_last[i];
                sel_valid_d   = req_valid[i];
                grant_oh_d[i] = 1'b1;
            end
        end
        ptr_adv_d = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            last_q   <= 1'b0;
            hdr_q    <= 1'b0;
            cnt_q    <= '0;
            tx_din_q <= '0;
            tx_en_q  <= 1'b0;
            ready_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            ready_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        grant_q <= arb_grant;
                        busy_q  <= 1'b1;
                        state_q <= ID_PREFIX ? HDR : SEND;
                    end
                end
                HDR: begin
                    tx_en_q  <= 1'b1;
                    tx_din_q <= hdr_byte(grant_q);
                    hdr_q    <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= WAIT;
                end
                SEND: begin
                    tx_en_q  <= 1'b1;
                    ready_q  <= grant_oh_d;
                    tx_din_q <= sel_byte_d;
                    last_q   <= sel_last_d;
                    hdr_q    <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (hdr_q || !last_q) begin
                            state_q <= NEXT;
                        end else begin
                            ptr_q   <= ptr_adv_d;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        ptr_q   <= ptr_adv_d;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                NEXT: begin
                    // Issue straight from NEXT so consecutive bytes are only two cycles apart.
                    if (sel_valid_d) begin
                        tx_en_q  <= 1'b1;
                        ready_q  <= grant_oh_d;
                        tx_din_q <= sel_byte_d;
                        last_q   <= sel_last_d;
                        hdr_q    <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= WAIT;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign tx_din      = tx_din_q;
    assign tx_enable   = tx_en_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: requester queues drive the arbiter, a UART model answers with done,
// and a monitor pops the expected byte on every tx_enable.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int TO    = 100;
    localparam int FRAME = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last  = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_din;
    logic           tx_enable;
    logic           tx_done = 1'b0;
    logic           busy;
    logic [3:0]     grant_id;
    logic           err_timeout;

    logic [N-1:0]   p_valid = '0;
    logic [N-1:0]   p_last  = '0;
    logic [8*N-1:0] p_data  = '0;
    logic [N-1:0]   p_ready;
    logic [7:0]     p_din;
    logic           p_enable;
    logic           p_done = 1'b0;
    logic           p_busy;
    logic [3:0]     p_grant;
    logic           p_err;

    uart_tx_arbiter #(.N_REQ(N), .ID_PREFIX(1'b0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_din(tx_din), .tx_enable(tx_enable), .tx_done(tx_done),
        .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
    );

    uart_tx_arbiter #(.N_REQ(N), .ID_PREFIX(1'b1), .TIMEOUT(TO)) dut_p (
        .clk(clk), .rst(rst),
        .req_valid(p_valid), .req_data(p_data), .req_last(p_last), .req_ready(p_ready),
        .tx_din(p_din), .tx_enable(p_enable), .tx_done(p_done),
        .busy(p_busy), .grant_id(p_grant), .err_timeout(p_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // requester model: {last, data} per entry, popped on the req_ready pulse
    logic [8:0] rq [N][$];
    always @(negedge clk) begin
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                h = rq[i][0];
                req_valid[i]          = 1'b1;
                req_last[i]           = h[8];
                req_data[i*8 +: 8]    = h[7:0];
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*8 +: 8]    = 8'h00;
            end
        end
    end

    // UART model + scoreboard monitor
    logic [7:0] exp_q [$];
    int         gap_log [$];
    int         en_log [$];
    logic       tx_act    = 1'b0;
    int         tx_cnt    = 0;
    logic [7:0] din_hold  = '0;
    bit         done_en   = 1'b1;
    int         last_done = 0;
    always @(negedge clk) begin
        logic [7:0] e;
        tx_done = 1'b0;
        if (!rst) begin
            tx_act = 1'b0;
        end else begin
            if (tx_act) begin
                tx_cnt = tx_cnt - 1;
                if (tx_cnt == 0) begin
                    tx_act = 1'b0;
                    if (done_en) begin
                        tx_done   = 1'b1;
                        last_done = cyc;
                        chk("din_held", {24'h0, tx_din}, {24'h0, din_hold});
                    end
                end
            end
            if (tx_enable) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte actual 0x%02h expected none", tx_din);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_din !== e) begin
                        errors++;
                        $display("FAIL tx_byte actual 0x%02h expected 0x%02h", tx_din, e);
                    end
                end
                gap_log.push_back(cyc - last_done);
                en_log.push_back(cyc);
                tx_act   = 1'b1;
                tx_cnt   = FRAME;
                din_hold = tx_din;
            end
        end
    end

    // prefix instance: single requester model, UART model and monitor
    logic [7:0] expp_q [$];
    int         p_ready_cnt = 0;
    int         p_act       = 0;
    always @(negedge clk) begin
        logic [7:0] e;
        p_done = 1'b0;
        if (p_ready != '0) begin
            p_ready_cnt += $countones(p_ready);
            p_valid = '0;
            p_last  = '0;
        end
        if (p_act > 0) begin
            p_act = p_act - 1;
            if (p_act == 0) p_done = 1'b1;
        end
        if (p_enable) begin
            checks++;
            if (expp_q.size() == 0) begin
                errors++;
                $display("FAIL prefix_byte actual 0x%02h expected none", p_din);
            end else begin
                e = expp_q.pop_front();
                if (p_din !== e) begin
                    errors++;
                    $display("FAIL prefix_byte actual 0x%02h expected 0x%02h", p_din, e);
                end
            end
            p_act = FRAME;
        end
    end

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += rq[i].size();
        return s;
    endfunction

    int load_cyc = 0;
    task automatic sync();
        @(posedge clk);
        #1;
        load_cyc = cyc;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy || tx_act || pending() != 0) && n < 2000);
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s actual still busy expected idle within 2000 cycles", name);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},  {31'h0, busy},        32'h0);
        chk({tag, "_en"},    {31'h0, tx_enable},   32'h0);
        chk({tag, "_din"},   {24'h0, tx_din},      32'h0);
        chk({tag, "_grant"}, {28'h0, grant_id},    32'h0);
        chk({tag, "_err"},   {31'h0, err_timeout}, 32'h0);
        chk({tag, "_ready"}, {28'h0, req_ready},   32'h0);
    endtask

    initial begin
        int n;
        int err_cyc;

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        // prefix: requester 3 sends 0x7E -> header 0xA3 then 0x7E, one ready pulse
        sync();
        expp_q.push_back(8'hA3);
        expp_q.push_back(8'h7E);
        p_data[31:24] = 8'h7E;
        p_last[3]     = 1'b1;
        p_valid[3]    = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((expp_q.size() != 0 || p_busy || p_act != 0) && n < 500);
        chk("prefix_done", {31'h0, n >= 500}, 32'h0);
        chk("prefix_ready_count", p_ready_cnt, 1);

        // single byte from requester 2
        en_log.delete();
        sync();
        exp_q.push_back(8'h5A);
        rq[2].push_back({1'b1, 8'h5A});
        wait_idle("single");
        chk("single_latency", en_log[0] - load_cyc, 2);
        chk("single_busy_low", {31'h0, busy}, 32'h0);

        // ptr now 3: requester 3 beats requester 0
        sync();
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h30);
        rq[0].push_back({1'b1, 8'h30});
        rq[3].push_back({1'b1, 8'h33});
        wait_idle("ptr3");

        // ptr 1 -> lone requester 3 leaves ptr at 0
        sync();
        exp_q.push_back(8'h03);
        rq[3].push_back({1'b1, 8'h03});
        wait_idle("to_ptr0");

        sync();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            rq[i].push_back({1'b1, 8'h10 + 8'(i)});
        end
        wait_idle("rr_ptr0");

        sync();
        exp_q.push_back(8'h21);
        rq[1].push_back({1'b1, 8'h21});
        wait_idle("to_ptr2");

        sync();
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h13);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'h10 + 8'(i)});
        wait_idle("rr_ptr2");

        // packet lock
        gap_log.delete();
        sync();
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'hB1);
        rq[0].push_back({1'b0, 8'hA1});
        rq[0].push_back({1'b0, 8'hA2});
        rq[0].push_back({1'b1, 8'hA3});
        rq[1].push_back({1'b1, 8'hB1});
        wait_idle("lock");
        chk("gap_byte2", gap_log[1], 2);
        chk("gap_byte3", gap_log[2], 2);
        chk("gap_next_pkt", gap_log[3], 3);

        // watchdog: first byte never completes
        done_en = 1'b0;
        en_log.delete();
        sync();
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hD3);
        exp_q.push_back(8'hC2);
        rq[2].push_back({1'b0, 8'hC1});
        rq[2].push_back({1'b1, 8'hC2});
        rq[3].push_back({1'b1, 8'hD3});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 400);
        err_cyc = cyc;
        done_en = 1'b1;
        chk("timeout_seen", {31'h0, err_timeout}, 32'h1);
        chk("timeout_cycles", err_cyc - en_log[0], TO);
        wait_idle("after_timeout");
        chk("err_sticky", {31'h0, err_timeout}, 32'h1);

        // reset during WAIT of a multi-byte packet from requester 1
        en_log.delete();
        sync();
        exp_q.push_back(8'hE1);
        rq[1].push_back({1'b0, 8'hE1});
        rq[1].push_back({1'b0, 8'hE2});
        rq[1].push_back({1'b1, 8'hE3});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (en_log.size() == 0 && n < 50);
        chk("midframe_started", {31'h0, n >= 50}, 32'h0);
        chk("midframe_grant", {28'h0, grant_id}, 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) rq[i].delete();
        check_reset("midrst");
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;

        sync();
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hF3);
        rq[3].push_back({1'b1, 8'hF3});
        rq[0].push_back({1'b1, 8'hF0});
        wait_idle("post_reset");
        chk("post_reset_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin packet arbiter that shares the single `UART_TX` transmitter among `N_REQ` byte-stream requesters. It sits between the requesters and `UART_TX`. It drives the transmitter's `din`/`enable` pair, waits for `done`, and holds the grant until the current requester's packet completes. An optional header byte tags each packet with the requester ID, and a watchdog flags a transmitter that never reports `done`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `ID_PREFIX`, default 0: 1 = send header byte `{4'hA, id[3:0]}` before each packet.
- `TIMEOUT`, default 65535: max cycles from `tx_enable` to `tx_done`; counter width `$clog2(TIMEOUT+1)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `req_valid` in N_REQ: requester i has a byte on `req_data[8i+:8]`.
- `req_data` in 8*N_REQ: byte per requester; must be stable while valid.
- `req_last` in N_REQ: byte offered by requester i is the last of its packet.
- `req_ready` out N_REQ: one-cycle pulse; the byte from requester i is consumed.
- `tx_din` out 8: to `UART_TX.din`; held from `tx_enable` until `tx_done`.
- `tx_enable` out 1: one-cycle start pulse to `UART_TX.enable`.
- `tx_done` in 1: one-cycle pulse from `UART_TX.done`.
- `busy` out 1: a packet is in progress (state != IDLE).
- `grant_id` out 4: index of the current owner; valid while `busy`.
- `err_timeout` out 1: sticky watchdog flag; cleared only by reset.

## Operation
- States: IDLE, HDR, SEND, WAIT, NEXT.
- **IDLE**: if any `req_valid`, grant the first valid index searching from `ptr` upward, modulo N_REQ. Latch `grant_id`. Go to HDR if `ID_PREFIX`, otherwise SEND.
- **HDR**: pulse `tx_enable` with `tx_din = {4'hA, grant_id}`. No `req_ready`. Go to WAIT and mark the byte as a header.
- **SEND**: pulse `tx_enable` and `req_ready[grant_id]` together. `tx_din = req_data[grant_id]`. Latch `req_last[grant_id]` as `last_q`. Go to WAIT.
- **WAIT**: on `tx_done`:
  - header byte → go to NEXT.
  - `last_q`=1 → set `ptr = grant_id+1` mod N_REQ and go to IDLE.
  - otherwise → go to NEXT.
- **NEXT**: if `req_valid[grant_id]`, go to SEND. Other requesters are ignored while the grant is held. There is no timeout in NEXT; a requester that stalls mid-packet keeps the grant.
- **Watchdog**: the counter clears on entry to WAIT and increments each WAIT cycle. On reaching TIMEOUT:
  - set `err_timeout`;
  - abort the packet: go to IDLE and advance `ptr` past `grant_id`;
  - the aborted byte counts as consumed.
- A `tx_done` outside WAIT is ignored.
- `tx_done` and the timeout in the same cycle: `tx_done` wins and `err_timeout` is not set.
- **Reset** (asynchronous, at any time including mid-frame): state=IDLE, `ptr`=0, `req_ready`=0, `tx_enable`=0, `tx_din`=8'h00, `busy`=0, `grant_id`=0, `err_timeout`=0. The partially sent frame is abandoned; `UART_TX` shares the same reset.

## Timing
- All outputs are registered.
- `req_valid` sampled high in IDLE at edge E0:
  - no prefix: `tx_enable` and `req_ready` are high during the cycle after E0+1.
  - with prefix: the header `tx_enable` comes at that point instead.
- `tx_done` sampled at edge Ed, with the next byte's valid already high:
  - next `tx_enable` is high during the cycle after Ed+1 (one NEXT cycle).
  - Byte-to-byte gap is therefore 2 cycles plus the frame time.
- `req_ready` is exactly one cycle wide. The requester must update data/valid/last on the following edge.
- `tx_din` stays constant from the `tx_enable` cycle through the `tx_done` cycle.
- Arbitration fairness: a continuously-valid requester waits at most N_REQ-1 packets.

## Structure
- Package `uart_pkg`:
  - state enum `arb_state_t`;
  - `HDR_NIBBLE = 4'hA`;
  - byte width constant 8.
- Sub-module `rr_arbiter`: combinational one-hot first-set search from `ptr`, parameterised by N_REQ, returning grant index and an any-valid flag.
- Integration: `uart_tx_arbiter` feeds `UART_TX` in place of a direct requester. The existing TX→RX loopback top is used to check delivered bytes.

## Test plan
- **Single byte.** Requester 2 sends 0x5A with last=1, N_REQ=4, no prefix → one `tx_enable`, RX gets 0x5A, `ptr` becomes 3, `busy` falls after `tx_done`.
- **Round robin.** All four requesters valid with single-byte packets 0x10/0x11/0x12/0x13, `ptr`=0 → RX order 0x10, 0x11, 0x12, 0x13. Repeat with `ptr`=2 → order 0x12, 0x13, 0x10, 0x11.
- **Packet lock.** Requester 0 sends 3-byte packet 0xA1, 0xA2, 0xA3 (last on 0xA3) while requester 1 is valid with 0xB1 → RX 0xA1, 0xA2, 0xA3, 0xB1.
- **Prefix.** `ID_PREFIX`=1, requester 3 sends 0x7E → RX 0xA3 then 0x7E; exactly one `req_ready` pulse.
- **Timeout.** `tx_done` tied low, TIMEOUT=100 → `err_timeout` set 100 cycles after `tx_enable`, state returns to IDLE, the next requester is granted, and the flag stays high until reset.
- **Reset mid-frame.** Assert reset during WAIT of a multi-byte packet → all outputs take their reset values asynchronously. After release, a new request is granted starting from index 0.
